// File: rtl/dnn_opt_mult.sv
// Two-layer 4-4-2 integer neural network: 5-bit signed operands, ReLU hidden layer,
// exact 17-bit signed outputs, fully pipelined with a fixed two-cycle latency.
module dnn_opt_mult (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_ready,
  input  logic signed [4:0]  x0,
  input  logic signed [4:0]  x1,
  input  logic signed [4:0]  x2,
  input  logic signed [4:0]  x3,
  input  logic signed [4:0]  w04,
  input  logic signed [4:0]  w14,
  input  logic signed [4:0]  w24,
  input  logic signed [4:0]  w34,
  input  logic signed [4:0]  w05,
  input  logic signed [4:0]  w15,
  input  logic signed [4:0]  w25,
  input  logic signed [4:0]  w35,
  input  logic signed [4:0]  w06,
  input  logic signed [4:0]  w16,
  input  logic signed [4:0]  w26,
  input  logic signed [4:0]  w36,
  input  logic signed [4:0]  w07,
  input  logic signed [4:0]  w17,
  input  logic signed [4:0]  w27,
  input  logic signed [4:0]  w37,
  input  logic signed [4:0]  w48,
  input  logic signed [4:0]  w58,
  input  logic signed [4:0]  w68,
  input  logic signed [4:0]  w78,
  input  logic signed [4:0]  w49,
  input  logic signed [4:0]  w59,
  input  logic signed [4:0]  w69,
  input  logic signed [4:0]  w79,
  output logic signed [16:0] out0,
  output logic signed [16:0] out1,
  output logic               out0_ready,
  output logic               out1_ready
);

  // 5x5 signed product; the true range -240..256 fits a 10-bit signed result.
  function automatic logic signed [9:0] mul5(input logic signed [4:0] a, input logic signed [4:0] b);
    logic signed [9:0] ae;
    logic signed [9:0] be;
    ae = {{5{a[4]}}, a};
    be = {{5{b[4]}}, b};
    return ae * be;
  endfunction

  function automatic logic [10:0] relu_dot(
    input logic signed [4:0] a0, input logic signed [4:0] a1,
    input logic signed [4:0] a2, input logic signed [4:0] a3,
    input logic signed [4:0] b0, input logic signed [4:0] b1,
    input logic signed [4:0] b2, input logic signed [4:0] b3);
    logic signed [9:0]  p0, p1, p2, p3;
    logic signed [11:0] s;
    p0 = mul5(a0, b0);
    p1 = mul5(a1, b1);
    p2 = mul5(a2, b2);
    p3 = mul5(a3, b3);
    s  = {{2{p0[9]}}, p0} + {{2{p1[9]}}, p1} + {{2{p2[9]}}, p2} + {{2{p3[9]}}, p3};
    if (s[11]) begin
      return 11'd0;
    end else begin
      return s[10:0];
    end
  endfunction

  // Hidden value is non-negative, so it is zero-extended before the signed multiply.
  function automatic logic signed [16:0] mul_hw(input logic [10:0] h, input logic signed [4:0] w);
    logic signed [16:0] he;
    logic signed [16:0] we;
    he = {6'd0, h};
    we = {{12{w[4]}}, w};
    return he * we;
  endfunction

  logic signed [4:0]  x_r    [4];
  logic signed [4:0]  w1_r   [4][4];   // [hidden][input]
  logic signed [4:0]  w2_r   [2][4];   // [output][hidden], stage 0
  logic signed [4:0]  w2_h_r [2][4];   // layer-2 weights travelling with the hidden values
  logic        [10:0] hid_r  [4];
  logic               v0_r;
  logic               v1_r;
  logic        [10:0] hid_s  [4];
  logic signed [16:0] o_s    [2];

  // Layer-1 dot products with ReLU from the captured operands.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      hid_s[j] = relu_dot(x_r[0], x_r[1], x_r[2], x_r[3],
                          w1_r[j][0], w1_r[j][1], w1_r[j][2], w1_r[j][3]);
    end
  end

  // Layer-2 weighted sums; worst case -65536 still fits 17 bits exactly.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      o_s[k] = mul_hw(hid_r[0], w2_h_r[k][0]) + mul_hw(hid_r[1], w2_h_r[k][1])
             + mul_hw(hid_r[2], w2_h_r[k][2]) + mul_hw(hid_r[3], w2_h_r[k][3]);
    end
  end

  // Three-stage pipeline: capture, hidden layer, outputs with ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_r       <= 1'b0;
      v1_r       <= 1'b0;
      out0       <= 17'sd0;
      out1       <= 17'sd0;
      out0_ready <= 1'b0;
      out1_ready <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_r[i]   <= 5'sd0;
        hid_r[i] <= 11'd0;
        for (int j = 0; j < 4; j++) begin
          w1_r[i][j] <= 5'sd0;
        end
        for (int k = 0; k < 2; k++) begin
          w2_r[k][i]   <= 5'sd0;
          w2_h_r[k][i] <= 5'sd0;
        end
      end
    end else begin
      v0_r <= in_ready;
      if (in_ready) begin
        x_r     <= '{x0, x1, x2, x3};
        w1_r[0] <= '{w04, w14, w24, w34};
        w1_r[1] <= '{w05, w15, w25, w35};
        w1_r[2] <= '{w06, w16, w26, w36};
        w1_r[3] <= '{w07, w17, w27, w37};
        w2_r[0] <= '{w48, w58, w68, w78};
        w2_r[1] <= '{w49, w59, w69, w79};
      end
      v1_r <= v0_r;
      if (v0_r) begin
        hid_r  <= hid_s;
        w2_h_r <= w2_r;
      end
      out0_ready <= v1_r;
      out1_ready <= v1_r;
      if (v1_r) begin
        out0 <= o_s[0];
        out1 <= o_s[1];
      end
    end
  end

endmodule

// File: tb/tb_dnn_opt_mult.sv
// Directed bench for dnn_opt_mult: hand-computed vectors, latency, back-to-back,
// idle and reset-abort scenarios.
module tb_dnn_opt_mult;

  logic               clk;
  logic               rst;
  logic               in_ready;
  logic signed [4:0]  x  [4];
  logic signed [4:0]  w1 [4][4];   // [hidden][input]
  logic signed [4:0]  w2 [2][4];   // [output][hidden]
  logic signed [16:0] out0;
  logic signed [16:0] out1;
  logic               out0_ready;
  logic               out1_ready;
  int                 errors;
  int                 checks;

  dnn_opt_mult dut (
    .clk(clk), .rst(rst), .in_ready(in_ready),
    .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
    .w04(w1[0][0]), .w14(w1[0][1]), .w24(w1[0][2]), .w34(w1[0][3]),
    .w05(w1[1][0]), .w15(w1[1][1]), .w25(w1[1][2]), .w35(w1[1][3]),
    .w06(w1[2][0]), .w16(w1[2][1]), .w26(w1[2][2]), .w36(w1[2][3]),
    .w07(w1[3][0]), .w17(w1[3][1]), .w27(w1[3][2]), .w37(w1[3][3]),
    .w48(w2[0][0]), .w58(w2[0][1]), .w68(w2[0][2]), .w78(w2[0][3]),
    .w49(w2[1][0]), .w59(w2[1][1]), .w69(w2[1][2]), .w79(w2[1][3]),
    .out0(out0), .out1(out1), .out0_ready(out0_ready), .out1_ready(out1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_all(input logic signed [4:0] v);
    for (int i = 0; i < 4; i++) begin
      x[i] = v;
      for (int j = 0; j < 4; j++) w1[i][j] = v;
      for (int k = 0; k < 2; k++) w2[k][i] = v;
    end
  endtask

  task automatic set_mixed();
    x     = '{5'sd4, 5'sd2, 5'sd4, 5'sd1};
    w1[0] = '{5'sd3, 5'sd2, 5'sd13, -5'sd6};
    w1[1] = '{-5'sd9, 5'sd1, -5'sd4, 5'sd14};
    w1[2] = '{5'sd3, 5'sd6, -5'sd15, 5'sd15};
    w1[3] = '{5'sd9, -5'sd10, 5'sd15, -5'sd10};
    w2[0] = '{5'sd0, -5'sd1, 5'sd3, -5'sd11};
    w2[1] = '{-5'sd12, -5'sd15, -5'sd15, 5'sd6};
  endtask

  task automatic set_positive();
    x     = '{5'sd4, 5'sd2, 5'sd4, 5'sd1};
    w1[0] = '{5'sd3, 5'sd2, 5'sd13, 5'sd0};
    w1[1] = '{5'sd0, 5'sd0, 5'sd0, 5'sd14};
    w1[2] = '{5'sd3, 5'sd6, 5'sd0, 5'sd15};
    w1[3] = '{5'sd9, 5'sd0, 5'sd15, 5'sd0};
    w2[0] = '{5'sd0, 5'sd0, 5'sd3, 5'sd11};
    w2[1] = '{5'sd12, 5'sd0, 5'sd0, 5'sd6};
  endtask

  // One in_ready pulse; returns at the falling edge just after the capture edge.
  task automatic capture();
    @(negedge clk);
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_ready = 1'b1;
    set_all(5'sd7);
    repeat (3) @(negedge clk);
    checks++;
    if (out0 !== 17'sd0 || out1 !== 17'sd0) begin
      errors++;
      $display("FAIL reset_out: out0=%0d out1=%0d expected 0 0", out0, out1);
    end
    checks++;
    if (out0_ready !== 1'b0 || out1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: %0b%0b expected 00", out0_ready, out1_ready);
    end
    in_ready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_op(input string name, input logic signed [16:0] e0,
                                input logic signed [16:0] e1);
    capture();
    @(negedge clk);
    checks++;
    if (out0_ready !== 1'b0 || out1_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_early_ready: %0b%0b expected 00", name, out0_ready, out1_ready);
    end
    @(negedge clk);
    checks++;
    if (out0_ready !== 1'b1 || out1_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: %0b%0b expected 11", name, out0_ready, out1_ready);
    end
    checks++;
    if (out0 !== e0 || out1 !== e1) begin
      errors++;
      $display("FAIL %s_value: out0=%0d out1=%0d expected %0d %0d", name, out0, out1, e0, e1);
    end
    @(negedge clk);
    checks++;
    if (out0_ready !== 1'b0 || out1_ready !== 1'b0 || out0 !== e0 || out1 !== e1) begin
      errors++;
      $display("FAIL %s_hold: ready=%0b%0b out0=%0d out1=%0d expected 00 %0d %0d",
               name, out0_ready, out1_ready, out0, out1, e0, e1);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_all(5'b10000);
    in_ready = 1'b1;
    @(negedge clk);
    set_all(5'sd15);
    @(negedge clk);
    in_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out0_ready !== 1'b1 || out1_ready !== 1'b1 || out0 !== -17'sd65536 || out1 !== -17'sd65536) begin
      errors++;
      $display("FAIL b2b_first: ready=%0b%0b out0=%0d out1=%0d expected 11 -65536 -65536",
               out0_ready, out1_ready, out0, out1);
    end
    @(negedge clk);
    checks++;
    if (out0_ready !== 1'b1 || out1_ready !== 1'b1 || out0 !== 17'sd54000 || out1 !== 17'sd54000) begin
      errors++;
      $display("FAIL b2b_second: ready=%0b%0b out0=%0d out1=%0d expected 11 54000 54000",
               out0_ready, out1_ready, out0, out1);
    end
    @(negedge clk);
    checks++;
    if (out0_ready !== 1'b0 || out1_ready !== 1'b0 || out0 !== 17'sd54000) begin
      errors++;
      $display("FAIL b2b_end: ready=%0b%0b out0=%0d expected 00 54000", out0_ready, out1_ready, out0);
    end
  endtask

  // Changing operands with in_ready low must neither pulse ready nor disturb the outputs.
  task automatic test_idle();
    set_all(5'b10000);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      x[c] = 5'sd9;
      checks++;
      if (out0_ready !== 1'b0 || out1_ready !== 1'b0 || out0 !== 17'sd54000 || out1 !== 17'sd54000) begin
        errors++;
        $display("FAIL idle_c%0d: ready=%0b%0b out0=%0d out1=%0d expected 00 54000 54000",
                 c, out0_ready, out1_ready, out0, out1);
      end
    end
  endtask

  // Reset one or two edges after capture; the aborted operation must never emit.
  task automatic test_reset_abort(input int delay);
    set_mixed();
    capture();
    if (delay > 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out0_ready !== 1'b0 || out1_ready !== 1'b0 || out0 !== 17'sd0 || out1 !== 17'sd0) begin
        errors++;
        $display("FAIL abort_d%0d_c%0d: ready=%0b%0b out0=%0d out1=%0d expected 00 0 0",
                 delay, c, out0_ready, out1_ready, out0, out1);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    in_ready = 1'b0;
    set_all(5'sd0);
    test_reset();
    set_mixed();
    test_single_op("mixed", -17'sd726, -17'sd348);
    set_positive();
    test_single_op("positive", 17'sd1173, 17'sd1392);
    set_all(5'b10000);
    test_single_op("minimum", -17'sd65536, -17'sd65536);
    set_all(5'sd15);
    test_single_op("maximum", 17'sd54000, 17'sd54000);
    test_back_to_back();
    test_idle();
    test_reset_abort(1);
    set_positive();
    test_single_op("after_reset", 17'sd1173, 17'sd1392);
    test_reset_abort(2);
    set_mixed();
    test_single_op("after_reset2", -17'sd726, -17'sd348);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
